// File: rtl/vliw_scoreboard.sv
// vliw_scoreboard: per-register countdown scoreboard raising RAW/WAW stalls and bypass flags for an N-slot VLIW issue stage
module vliw_scoreboard #(
  parameter int NUM_SLOTS = 2,
  parameter int NUM_REGS  = 8,
  parameter int REG_W     = 3,
  parameter int LAT_W     = 2,
  parameter int FWD_LVL   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SLOTS-1:0]       i_issue_valid,
  input  logic [NUM_SLOTS-1:0]       i_issue_wr,
  input  logic [NUM_SLOTS*REG_W-1:0] i_issue_rd,
  input  logic [NUM_SLOTS*LAT_W-1:0] i_issue_lat,
  input  logic [NUM_SLOTS*REG_W-1:0] i_src_rn,
  input  logic [NUM_SLOTS*REG_W-1:0] i_src_rm,
  input  logic [NUM_SLOTS-1:0]       i_rn_used,
  input  logic [NUM_SLOTS-1:0]       i_rm_used,
  input  logic                       i_flush,
  output logic                       o_stall,
  output logic [NUM_SLOTS-1:0]       o_fwd_rn,
  output logic [NUM_SLOTS-1:0]       o_fwd_rm,
  output logic [NUM_REGS-1:0]        o_busy,
  output logic                       o_waw_err,
  output logic [15:0]                o_stall_count
);
  localparam logic [LAT_W-1:0] FWD = LAT_W'(FWD_LVL);
  logic [LAT_W-1:0] r_cnt [NUM_REGS];
  logic             r_waw_err;
  logic [15:0]      r_stall_count;
  logic [LAT_W-1:0] w_cnt_rn [NUM_SLOTS];
  logic [LAT_W-1:0] w_cnt_rm [NUM_SLOTS];
  logic [LAT_W-1:0] w_cnt_rd [NUM_SLOTS];
  logic [LAT_W-1:0] w_lat [NUM_SLOTS];
  logic [REG_W-1:0] w_rd [NUM_SLOTS];
  logic             w_hazard, w_dup, w_accept;
  always_comb begin
    w_hazard = 1'b0;
    w_dup = 1'b0;
    o_fwd_rn = '0;
    o_fwd_rm = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      w_rd[s] = i_issue_rd[s*REG_W +: REG_W];
      w_lat[s] = i_issue_lat[s*LAT_W +: LAT_W];
      w_cnt_rn[s] = r_cnt[i_src_rn[s*REG_W +: REG_W]];
      w_cnt_rm[s] = r_cnt[i_src_rm[s*REG_W +: REG_W]];
      w_cnt_rd[s] = r_cnt[w_rd[s]];
      o_fwd_rn[s] = i_rn_used[s] && w_cnt_rn[s] != '0 && w_cnt_rn[s] <= FWD;
      o_fwd_rm[s] = i_rm_used[s] && w_cnt_rm[s] != '0 && w_cnt_rm[s] <= FWD;
      w_hazard |= i_issue_valid[s] && ((i_rn_used[s] && w_cnt_rn[s] > FWD) ||
                                       (i_rm_used[s] && w_cnt_rm[s] > FWD) ||
                                       (i_issue_wr[s] && w_cnt_rd[s] > w_lat[s]));
      for (int t = 0; t < s; t++)
        w_dup |= i_issue_valid[s] && i_issue_wr[s] && i_issue_valid[t] && i_issue_wr[t] && w_rd[s] == w_rd[t];
    end
  end
  assign o_stall = w_hazard && !i_flush;
  assign w_accept = |i_issue_valid && !w_hazard && !i_flush;
  always_comb begin
    o_busy = '0;
    for (int r = 0; r < NUM_REGS; r++) o_busy[r] = r_cnt[r] != '0;
  end
  assign o_waw_err = r_waw_err;
  assign o_stall_count = r_stall_count;
  // later slots assign after earlier ones, so the highest slot wins a duplicate rd
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= '0;
      r_waw_err <= 1'b0;
      r_stall_count <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= r_cnt[r] - LAT_W'(r_cnt[r] != '0);
      if (w_accept)
        for (int s = 0; s < NUM_SLOTS; s++)
          if (i_issue_valid[s] && i_issue_wr[s] && w_lat[s] != '0) r_cnt[w_rd[s]] <= w_lat[s];
      r_waw_err <= w_accept && w_dup;
      r_stall_count <= r_stall_count + 16'(o_stall && r_stall_count != 16'hFFFF);
    end
  end
endmodule

// File: tb/tb_vliw_scoreboard.sv
// tb_vliw_scoreboard: random and directed stimulus on two scoreboard configurations checked against a countdown model
module tb_vliw_scoreboard;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] v, w, un, um;
  logic fl;
  logic [2:0] rd [2];
  logic [2:0] rn [2];
  logic [2:0] rm [2];
  logic [1:0] la [2];
  logic [2:0] lb [2];
  logic o_st [2];
  logic [1:0] o_fn [2];
  logic [1:0] o_fm [2];
  logic [7:0] o_bz [2];
  logic o_we [2];
  logic [15:0] o_sc [2];
  int pend [2][8];
  int scnt [2];
  bit wexp [2];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  vliw_scoreboard #(.LAT_W(2), .FWD_LVL(1)) u0 (
    .clk(clk), .reset(reset), .i_issue_valid(v), .i_issue_wr(w),
    .i_issue_rd({rd[1], rd[0]}), .i_issue_lat({la[1], la[0]}),
    .i_src_rn({rn[1], rn[0]}), .i_src_rm({rm[1], rm[0]}),
    .i_rn_used(un), .i_rm_used(um), .i_flush(fl),
    .o_stall(o_st[0]), .o_fwd_rn(o_fn[0]), .o_fwd_rm(o_fm[0]),
    .o_busy(o_bz[0]), .o_waw_err(o_we[0]), .o_stall_count(o_sc[0]));
  vliw_scoreboard #(.LAT_W(3), .FWD_LVL(0)) u1 (
    .clk(clk), .reset(reset), .i_issue_valid(v), .i_issue_wr(w),
    .i_issue_rd({rd[1], rd[0]}), .i_issue_lat({lb[1], lb[0]}),
    .i_src_rn({rn[1], rn[0]}), .i_src_rm({rm[1], rm[0]}),
    .i_rn_used(un), .i_rm_used(um), .i_flush(fl),
    .o_stall(o_st[1]), .o_fwd_rn(o_fn[1]), .o_fwd_rm(o_fm[1]),
    .o_busy(o_bz[1]), .o_waw_err(o_we[1]), .o_stall_count(o_sc[1]));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask
  task automatic idle();
    v = 0; w = 0; un = 0; um = 0; fl = 0;
    for (int s = 0; s < 2; s++) begin
      rd[s] = 0; rn[s] = 0; rm[s] = 0; la[s] = 0; lb[s] = 0;
    end
  endtask
  // called just after the falling edge with inputs in place; checks then advances the model past the next rising edge
  task automatic step();
    int lvl, lt;
    bit st, acc, dup;
    logic [1:0] efn, efm;
    logic [7:0] eb;
    #1;
    dup = v == 2'b11 && w == 2'b11 && rd[0] == rd[1];
    for (int k = 0; k < 2; k++) begin
      lvl = k == 0 ? 1 : 0;
      st = 0; efn = 0; efm = 0; eb = 0;
      for (int s = 0; s < 2; s++) begin
        lt = k == 0 ? int'(la[s]) : int'(lb[s]);
        efn[s] = un[s] && pend[k][rn[s]] > 0 && pend[k][rn[s]] <= lvl;
        efm[s] = um[s] && pend[k][rm[s]] > 0 && pend[k][rm[s]] <= lvl;
        if (v[s] && ((un[s] && pend[k][rn[s]] > lvl) || (um[s] && pend[k][rm[s]] > lvl) || (w[s] && pend[k][rd[s]] > lt))) st = 1;
      end
      if (fl) st = 0;
      for (int r = 0; r < 8; r++) eb[r] = pend[k][r] != 0;
      chk($sformatf("stall%0d", k), o_st[k], st);
      chk($sformatf("fwd_rn%0d", k), o_fn[k], efn);
      chk($sformatf("fwd_rm%0d", k), o_fm[k], efm);
      chk($sformatf("busy%0d", k), o_bz[k], eb);
      chk($sformatf("waw_err%0d", k), o_we[k], wexp[k]);
      chk($sformatf("stall_count%0d", k), o_sc[k], scnt[k]);
      acc = v != 0 && !st && !fl;
      if (reset) begin
        for (int r = 0; r < 8; r++) pend[k][r] = 0;
        scnt[k] = 0;
        wexp[k] = 0;
      end else begin
        if (st && scnt[k] < 65535) scnt[k]++;
        for (int r = 0; r < 8; r++) if (pend[k][r] > 0) pend[k][r]--;
        if (acc)
          for (int s = 0; s < 2; s++) begin
            lt = k == 0 ? int'(la[s]) : int'(lb[s]);
            if (v[s] && w[s] && lt != 0) pend[k][rd[s]] = lt;
          end
        wexp[k] = acc && dup;
      end
    end
  endtask
  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); idle(); step();
    end
  endtask
  initial begin
    idle();
    reset = 1;
    @(negedge clk); step();
    @(negedge clk); step();
    reset = 0;
    chk("rst_busy", o_bz[0], 0);
    chk("rst_count", o_sc[0], 0);
    @(negedge clk); idle(); v = 2'b01; w = 2'b01; rd[0] = 3; la[0] = 3; lb[0] = 3; step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); v = 2'b10; um = 2'b10; rm[1] = 3; step();
    end
    chk("t1_fwd_rm1", o_fm[0][1], 1);
    chk("t1_no_stall", o_st[0], 0);
    drain(8);
    @(negedge clk); idle(); v = 2'b11; w = 2'b11; rd[0] = 5; rd[1] = 5; la[0] = 1; la[1] = 3; lb[0] = 1; lb[1] = 3; step();
    @(negedge clk); idle(); step();
    chk("t3_busy5", o_bz[0][5], 1);
    chk("t3_waw", o_we[0], 1);
    @(negedge clk); idle(); step();
    chk("t3_waw_once", o_we[0], 0);
    drain(8);
    @(negedge clk); idle(); v = 2'b01; w = 2'b01; rd[0] = 4; la[0] = 3; lb[0] = 3; step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle(); v = 2'b01; w = 2'b01; rd[0] = 4; la[0] = 1; lb[0] = 1; step();
    end
    drain(8);
    @(negedge clk); idle(); v = 2'b01; w = 2'b01; rd[0] = 4; la[0] = 3; lb[0] = 3; step();
    @(negedge clk); idle(); v = 2'b01; un = 2'b01; rn[0] = 4; fl = 1; step();
    chk("t5_flush", o_st[0], 0);
    drain(8);
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      reset = $urandom_range(0, 199) == 0;
      v = 2'($urandom); w = 2'($urandom); un = 2'($urandom); um = 2'($urandom);
      fl = $urandom_range(0, 7) == 0;
      for (int s = 0; s < 2; s++) begin
        rd[s] = 3'($urandom_range(0, 3)); rn[s] = 3'($urandom_range(0, 3)); rm[s] = 3'($urandom_range(0, 3));
        la[s] = 2'($urandom); lb[s] = 3'($urandom);
      end
      step();
    end
    reset = 0;
    for (int i = 0; i < 75000; i++) begin
      @(negedge clk); idle(); v = 2'b11; w = 2'b01; rd[0] = 0; la[0] = 3; lb[0] = 7; un = 2'b10; rn[1] = 0; step();
    end
    chk("sat_count", o_sc[1], 16'hFFFF);
    @(negedge clk); reset = 1; step();
    @(negedge clk); reset = 0; idle(); v = 2'b10; un = 2'b10; rn[1] = 0; step();
    chk("rst_mid_busy", o_bz[1], 0);
    chk("rst_mid_count", o_sc[1], 0);
    chk("rst_mid_nostall", o_st[1], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
